pla_cfg_loader: RTL and testbench
=================================

Name: pla_cfg_loader

Overview:
Configuration controller for the pla block. It accepts a streamed load of the AND-plane select words and the OR-plane select words into a shadow table. It then commits the whole table atomically to the active select buses that drive the pla instance. The pla never sees a partially written configuration, and the active plane holds its last committed value between loads.

Parameters:
IN_WIDTH, 4, PLA input count; each AND select word is 2*IN_WIDTH bits (true/complement select per input).
OUT_WIDTH, 4, PLA output count; number of OR select words.
AND_WIDTH, 4, number of product terms; number of AND select words and width of each OR select word.
CFG_W, 8, cfg_data width; must be >= 2*IN_WIDTH and >= AND_WIDTH (elaboration-time check).

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  pulse; begin a new load sequence.
abort  in  1  pulse; discard the in-progress load.
cfg_valid  in  1  cfg_data is valid.
cfg_ready  out  1  loader accepts a word this cycle.
cfg_data  in  CFG_W  select word, LSB-aligned.
and_sel_flat  out  AND_WIDTH*2*IN_WIDTH  active AND selects; entry k occupies bits [k*2*IN_WIDTH +: 2*IN_WIDTH].
or_sel_flat  out  OUT_WIDTH*AND_WIDTH  active OR selects; entry j occupies bits [j*AND_WIDTH +: AND_WIDTH].
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse; the new configuration is active.
err  out  1  one-cycle pulse; a start arrived during a load.
cfg_gen  out  8  commit count; wraps from 255 to 0.

Behaviour:
- Reset (async assert, sync release): state=IDLE; shadow and active tables = 0; cfg_ready=0, busy=0, done=0, err=0, cfg_gen=0.
- States: IDLE, LOAD_AND, LOAD_OR, COMMIT. Word index counter is log2 of max(AND_WIDTH, OUT_WIDTH) bits wide.
- IDLE:
  - cfg_ready=0; cfg_valid is ignored.
  - start with abort low: index=0, next state LOAD_AND.
- LOAD_AND:
  - cfg_ready=1. A transfer is cfg_valid&cfg_ready at a clock edge.
  - On each transfer: shadow_and[index] <= cfg_data[2*IN_WIDTH-1:0], then index++.
  - The transfer at index AND_WIDTH-1 moves to LOAD_OR with index=0.
  - Gaps in cfg_valid stall the sequence indefinitely, with no timeout.
- LOAD_OR:
  - cfg_ready=1. On each transfer: shadow_or[index] <= cfg_data[AND_WIDTH-1:0].
  - The transfer at index OUT_WIDTH-1 moves to COMMIT.
- COMMIT (exactly one cycle):
  - cfg_ready=0.
  - At the edge ending this cycle: active <= shadow, cfg_gen++, done <= 1, state <= IDLE.
  - done is high during the first cycle in which the new active values are visible.
- Latency: the last word is accepted at edge E0. Active outputs change and done=1 after E1, so done is high for the cycle E1..E2.
- Active outputs are registered and change only on a COMMIT edge or on reset.
- abort, any state:
  - Next state IDLE and index=0.
  - Shadow contents are don't-care; active tables and cfg_gen are unchanged; no done.
  - abort wins over start and over cfg_valid in the same cycle.
  - abort in COMMIT cancels the commit.
- start in LOAD_AND or LOAD_OR (abort low):
  - err pulses for one cycle; restart at LOAD_AND with index=0.
  - Any transfer in that cycle is discarded.
- start in COMMIT: the commit completes, err pulses, and the next state is LOAD_AND.
- Reset mid-load: everything returns to reset values, including the active tables (the pla sees all-zero selects).

Decomposition:
- Package pla_cfg_pkg holds:
  - state enum (IDLE, LOAD_AND, LOAD_OR, COMMIT);
  - width helper functions (and-word width 2*IN_WIDTH, index width);
  - default parameter constants.
- One sub-module, pla_sel_bank: a parameterised shadow+active register array with a write port (index, data, we), a commit strobe and a flattened active output. It is instantiated twice, once for the AND plane and once for the OR plane. The FSM, counter, handshake and cfg_gen stay in pla_cfg_loader.

Test Plan:
- Default params: reset, start, AND words 0x01,0x02,0x03,0x04, OR words 0x1,0x2,0x3,0x4 back-to-back -> and_sel_flat=0x04030201 and or_sel_flat=0x4321 one edge after the last transfer edge +1; done=1 for one cycle; cfg_gen=1; busy low after.
- Same load with cfg_valid low on alternate cycles -> identical result; cfg_ready stays high throughout LOAD; done fires exactly once.
- Commit the previous table, start, load 3 AND words 0xFF, abort -> and_sel_flat stays 0x04030201; no done; cfg_gen unchanged; cfg_ready=0 next cycle.
- start again after 2 words -> err pulse; the following 8 words 0x10..0x13 and 0x5..0x8 -> and_sel_flat=0x13121110, or_sel_flat=0x8765.
- Deassert rst_n mid-way through LOAD_OR, asynchronously between edges -> outputs 0, cfg_gen 0, state IDLE immediately without waiting for an edge.
- 256 consecutive full loads -> cfg_gen wraps to 0; start and abort in the same cycle from IDLE -> stays IDLE, busy=0.

Source files
------------

// File: rtl/pla_cfg_pkg.sv
// Shared types and width helpers for the PLA configuration loader.
package pla_cfg_pkg;

  localparam int unsigned DefInWidth  = 4;
  localparam int unsigned DefOutWidth = 4;
  localparam int unsigned DefAndWidth = 4;
  localparam int unsigned DefCfgW     = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLoadAnd,
    StLoadOr,
    StCommit
  } state_e;

  // One true/complement select bit pair per PLA input.
  function automatic int unsigned and_word_w(input int unsigned in_width);
    return 2 * in_width;
  endfunction

  // Word index must cover the longer of the two planes.
  function automatic int unsigned idx_w(input int unsigned and_width,
                                        input int unsigned out_width);
    int unsigned m;
    m = (and_width > out_width) ? and_width : out_width;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pla_cfg_loader_if.sv
// Streamed configuration handshake between a config source and the loader.
interface pla_cfg_loader_if
  import pla_cfg_pkg::*;
#(
  parameter int unsigned CFG_W = DefCfgW
);
  logic             start;
  logic             abort;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CFG_W-1:0] cfg_data;

  modport master (output start, abort, cfg_valid, cfg_data, input cfg_ready);
  modport slave  (input start, abort, cfg_valid, cfg_data, output cfg_ready);
endinterface

// File: rtl/pla_sel_bank.sv
// Shadow register array with an atomic copy into a flattened active image.
module pla_sel_bank #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8,
  parameter int unsigned IdxW  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [IdxW-1:0]        idx_i,
  input  logic [Width-1:0]       data_i,
  input  logic                   we_i,
  input  logic                   commit_i,
  output logic [Depth*Width-1:0] active_o
);

  logic [Width-1:0]       shadow_q [Depth];
  logic [Depth*Width-1:0] active_q;

  // Shadow table: written one word at a time during a load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(Depth); k++) shadow_q[k] <= '0;
    end else if (we_i) begin
      shadow_q[idx_i] <= data_i;
    end
  end

  // Active image: whole table replaced in a single edge so the PLA never sees a mix.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= '0;
    end else if (commit_i) begin
      for (int k = 0; k < int'(Depth); k++) active_q[k*Width +: Width] <= shadow_q[k];
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/pla_cfg_loader.sv
// Loads AND/OR plane select words into shadow banks and commits them atomically.
module pla_cfg_loader
  import pla_cfg_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = DefInWidth,
  parameter int unsigned OUT_WIDTH = DefOutWidth,
  parameter int unsigned AND_WIDTH = DefAndWidth,
  parameter int unsigned CFG_W     = DefCfgW
) (
  input  logic                            clk,
  input  logic                            rst_n,
  pla_cfg_loader_if.slave                 cfg_if,
  output logic [AND_WIDTH*2*IN_WIDTH-1:0] and_sel_flat_o,
  output logic [OUT_WIDTH*AND_WIDTH-1:0]  or_sel_flat_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            err_o,
  output logic [7:0]                      cfg_gen_o
);

  localparam int unsigned AndW = and_word_w(IN_WIDTH);
  localparam int unsigned IdxW = idx_w(AND_WIDTH, OUT_WIDTH);
  localparam logic [IdxW-1:0] AndLast = IdxW'(AND_WIDTH - 1);
  localparam logic [IdxW-1:0] OrLast  = IdxW'(OUT_WIDTH - 1);

  if (CFG_W < AndW || CFG_W < AND_WIDTH) begin : g_bad_cfg_w
    $error("pla_cfg_loader: CFG_W too narrow for the select words");
  end

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [7:0]      gen_q, gen_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            ready, and_we, or_we, commit;

  // State, index, generation counter and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      gen_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gen_q   <= gen_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state, handshake and bank write/commit strobes; abort overrides everything.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gen_d   = gen_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ready   = 1'b0;
    and_we  = 1'b0;
    or_we   = 1'b0;
    commit  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_if.start) begin
          state_d = StLoadAnd;
          idx_d   = '0;
        end
      end
      StLoadAnd, StLoadOr: begin
        ready = 1'b1;
        if (cfg_if.start) begin
          // Restart discards any word presented in the same cycle.
          err_d   = 1'b1;
          state_d = StLoadAnd;
          idx_d   = '0;
        end else if (cfg_if.cfg_valid) begin
          if (state_q == StLoadAnd) begin
            and_we = 1'b1;
            if (idx_q == AndLast) begin
              state_d = StLoadOr;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end else begin
            or_we = 1'b1;
            if (idx_q == OrLast) begin
              state_d = StCommit;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end
        end
      end
      StCommit: begin
        commit  = 1'b1;
        gen_d   = gen_q + 8'd1;
        done_d  = 1'b1;
        idx_d   = '0;
        state_d = StIdle;
        if (cfg_if.start) begin
          err_d   = 1'b1;
          state_d = StLoadAnd;
        end
      end
      default: state_d = StIdle;
    endcase

    if (cfg_if.abort) begin
      state_d = StIdle;
      idx_d   = '0;
      gen_d   = gen_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      and_we  = 1'b0;
      or_we   = 1'b0;
      commit  = 1'b0;
    end
  end

  assign cfg_if.cfg_ready = ready;
  assign busy_o           = (state_q != StIdle);
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign cfg_gen_o        = gen_q;

  pla_sel_bank #(
    .Depth (AND_WIDTH),
    .Width (AndW),
    .IdxW  (IdxW)
  ) u_and_bank (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .idx_i    (idx_q),
    .data_i   (cfg_if.cfg_data[AndW-1:0]),
    .we_i     (and_we),
    .commit_i (commit),
    .active_o (and_sel_flat_o)
  );

  pla_sel_bank #(
    .Depth (OUT_WIDTH),
    .Width (AND_WIDTH),
    .IdxW  (IdxW)
  ) u_or_bank (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .idx_i    (idx_q),
    .data_i   (cfg_if.cfg_data[AND_WIDTH-1:0]),
    .we_i     (or_we),
    .commit_i (commit),
    .active_o (or_sel_flat_o)
  );

endmodule

// File: tb/tb_pla_cfg_loader.sv
// Self-checking bench for pla_cfg_loader with a word-list reference model.
module tb_pla_cfg_loader;

  localparam int unsigned InW  = 4;
  localparam int unsigned OutW = 4;
  localparam int unsigned AndN = 4;
  localparam int unsigned CfgW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] and_sel;
  logic [15:0] or_sel;
  logic        busy, done, err;
  logic [7:0]  cfg_gen;

  int checks = 0;
  int errors = 0;

  // Reference model: the last committed word lists and commit count.
  logic [7:0]  aw [4];
  logic [7:0]  ow [4];
  logic [31:0] m_and = '0;
  logic [15:0] m_or = '0;
  logic [7:0]  m_gen = '0;

  always #5 clk = ~clk;

  pla_cfg_loader_if #(.CFG_W(CfgW)) cfg_if ();

  pla_cfg_loader #(
    .IN_WIDTH  (InW),
    .OUT_WIDTH (OutW),
    .AND_WIDTH (AndN),
    .CFG_W     (CfgW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_if         (cfg_if),
    .and_sel_flat_o (and_sel),
    .or_sel_flat_o  (or_sel),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err),
    .cfg_gen_o      (cfg_gen)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    cfg_if.start = 1'b1;
    tick();
    cfg_if.start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int gap);
    cfg_if.cfg_valid = 1'b0;
    repeat (gap) tick();
    cfg_if.cfg_data  = w;
    cfg_if.cfg_valid = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = 8'($urandom);
  endtask

  task automatic send_all(input int max_gap);
    for (int k = 0; k < 4; k++) send_word(aw[k], $urandom_range(max_gap, 0));
    for (int j = 0; j < 4; j++) send_word(ow[j], $urandom_range(max_gap, 0));
  endtask

  task automatic randomize_words();
    for (int k = 0; k < 4; k++) begin
      aw[k] = 8'($urandom);
      ow[k] = 8'($urandom);
    end
  endtask

  // Active AND image is the word list end to end; OR words keep only AND_WIDTH bits.
  task automatic model_commit();
    m_and = '0;
    m_or  = '0;
    for (int k = 0; k < 4; k++) m_and = m_and | (32'(aw[k]) << (8 * k));
    for (int j = 0; j < 4; j++) m_or = m_or | (16'(ow[j] & 8'h0F) << (4 * j));
    m_gen = m_gen + 8'd1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({and_sel, or_sel, cfg_gen} !== '0) begin
      errors++;
      $display("FAIL reset_tables: got and=%h or=%h gen=%0d want 0", and_sel, or_sel, cfg_gen);
    end
    checks++;
    if ({busy, done, err, cfg_if.cfg_ready} !== 4'b0) begin
      errors++;
      $display("FAIL reset_status: got busy/done/err/ready=%b want 0000",
               {busy, done, err, cfg_if.cfg_ready});
    end
    #6 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    aw = '{8'h01, 8'h02, 8'h03, 8'h04};
    ow = '{8'h01, 8'h02, 8'h03, 8'h04};
    pulse_start();
    send_all(0);
    checks++;
    if (done !== 1'b0 || and_sel !== m_and) begin
      errors++;
      $display("FAIL basic_early: got done=%b and=%h want 0 %h", done, and_sel, m_and);
    end
    tick();
    model_commit();
    checks++;
    if (and_sel !== m_and || or_sel !== m_or || and_sel !== 32'h04030201) begin
      errors++;
      $display("FAIL basic_tables: got and=%h or=%h want %h %h", and_sel, or_sel, m_and, m_or);
    end
    checks++;
    if (done !== 1'b1 || cfg_gen !== m_gen) begin
      errors++;
      $display("FAIL basic_done: got done=%b gen=%0d want 1 %0d", done, cfg_gen, m_gen);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_after: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_gapped();
    int done_cnt = 0;
    int not_ready = 0;
    logic [7:0] words [8];
    for (int k = 0; k < 4; k++) begin
      words[k]     = aw[k];
      words[k + 4] = ow[k];
    end
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      cfg_if.cfg_valid = 1'b0;
      tick();
      if (cfg_if.cfg_ready !== 1'b1) not_ready++;
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_data  = words[i];
      tick();
    end
    cfg_if.cfg_valid = 1'b0;
    checks++;
    if (not_ready != 0) begin
      errors++;
      $display("FAIL gapped_ready: got %0d low cycles want 0", not_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    model_commit();
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL gapped_done_count: got %0d want 1", done_cnt);
    end
    checks++;
    if (and_sel !== m_and || or_sel !== m_or || cfg_gen !== m_gen) begin
      errors++;
      $display("FAIL gapped_tables: got %h %h %0d want %h %h %0d",
               and_sel, or_sel, cfg_gen, m_and, m_or, m_gen);
    end
  endtask

  task automatic test_abort();
    int done_cnt = 0;
    pulse_start();
    for (int i = 0; i < 3; i++) send_word(8'hFF, 0);
    cfg_if.abort     = 1'b1;
    cfg_if.cfg_valid = 1'b1;
    tick();
    cfg_if.abort     = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    checks++;
    if (cfg_if.cfg_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got ready=%b busy=%b want 0 0", cfg_if.cfg_ready, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt != 0 || and_sel !== m_and || cfg_gen !== m_gen) begin
      errors++;
      $display("FAIL abort_hold: got done_cnt=%0d and=%h gen=%0d want 0 %h %0d",
               done_cnt, and_sel, cfg_gen, m_and, m_gen);
    end
  endtask

  task automatic test_restart_err();
    pulse_start();
    send_word(8'hA5, 0);
    send_word(8'h5A, 0);
    cfg_if.start     = 1'b1;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = 8'hEE;
    tick();
    cfg_if.start     = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b1 || cfg_if.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_err: got err=%b busy=%b ready=%b want 111",
               err, busy, cfg_if.cfg_ready);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL restart_err_pulse: got err=%b want 0", err);
    end
    aw = '{8'h10, 8'h11, 8'h12, 8'h13};
    ow = '{8'h05, 8'h06, 8'h07, 8'h08};
    send_all(0);
    tick();
    model_commit();
    checks++;
    if (done !== 1'b1 || and_sel !== 32'h13121110 || or_sel !== 16'h8765) begin
      errors++;
      $display("FAIL restart_tables: got done=%b and=%h or=%h want 1 13121110 8765",
               done, and_sel, or_sel);
    end
  endtask

  task automatic test_commit_edges();
    randomize_words();
    pulse_start();
    send_all(1);
    cfg_if.start = 1'b1;
    tick();
    cfg_if.start = 1'b0;
    model_commit();
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b1 || and_sel !== m_and ||
        cfg_gen !== m_gen) begin
      errors++;
      $display("FAIL commit_start: got done=%b err=%b busy=%b and=%h gen=%0d want 111 %h %0d",
               done, err, busy, and_sel, cfg_gen, m_and, m_gen);
    end
    tick();
    aw = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    ow = '{8'h0C, 8'h0A, 8'h0F, 8'h0E};
    send_all(0);
    cfg_if.abort = 1'b1;
    tick();
    cfg_if.abort = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || and_sel !== m_and || or_sel !== m_or ||
        cfg_gen !== m_gen) begin
      errors++;
      $display("FAIL commit_abort: got done=%b busy=%b and=%h or=%h gen=%0d want 0 0 %h %h %0d",
               done, busy, and_sel, or_sel, cfg_gen, m_and, m_or, m_gen);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 20; n++) begin
      randomize_words();
      pulse_start();
      send_all(2);
      tick();
      model_commit();
      if (and_sel !== m_and || or_sel !== m_or || cfg_gen !== m_gen || done !== 1'b1) begin
        bad++;
        $display("FAIL random_load %0d: got %h %h %0d done=%b want %h %h %0d",
                 n, and_sel, or_sel, cfg_gen, done, m_and, m_or, m_gen);
      end
      tick();
    end
    checks++;
    if (bad != 0) errors++;
  endtask

  task automatic test_reset_mid();
    randomize_words();
    pulse_start();
    for (int k = 0; k < 4; k++) send_word(aw[k], 0);
    send_word(ow[0], 0);
    send_word(ow[1], 0);
    #3 rst_n = 1'b0;
    #1;
    m_and = '0;
    m_or  = '0;
    m_gen = '0;
    checks++;
    if (and_sel !== m_and || or_sel !== m_or || cfg_gen !== m_gen || busy !== 1'b0 ||
        cfg_if.cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got %h %h %0d busy=%b ready=%b want all 0",
               and_sel, or_sel, cfg_gen, busy, cfg_if.cfg_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 256; n++) begin
      randomize_words();
      pulse_start();
      send_all(0);
      tick();
      model_commit();
      if (n == 254) begin
        checks++;
        if (cfg_gen !== 8'd255) begin
          errors++;
          $display("FAIL wrap_255: got %0d want 255", cfg_gen);
        end
      end
    end
    checks++;
    if (cfg_gen !== m_gen || cfg_gen !== 8'd0 || and_sel !== m_and || or_sel !== m_or) begin
      errors++;
      $display("FAIL wrap_zero: got gen=%0d and=%h or=%h want 0 %h %h",
               cfg_gen, and_sel, or_sel, m_and, m_or);
    end
    tick();
  endtask

  task automatic test_start_abort_idle();
    cfg_if.start = 1'b1;
    cfg_if.abort = 1'b1;
    tick();
    cfg_if.start = 1'b0;
    cfg_if.abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || cfg_if.cfg_ready !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_idle: got busy=%b ready=%b err=%b want 000",
               busy, cfg_if.cfg_ready, err);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || cfg_gen !== m_gen) begin
      errors++;
      $display("FAIL start_abort_hold: got busy=%b gen=%0d want 0 %0d", busy, cfg_gen, m_gen);
    end
  endtask

  initial begin
    cfg_if.start     = 1'b0;
    cfg_if.abort     = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = '0;
    test_reset();
    test_basic();
    test_gapped();
    test_abort();
    test_restart_err();
    test_commit_edges();
    test_random();
    test_reset_mid();
    test_wrap();
    test_start_abort_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
